// File: rtl/lfsr_challenge_ctrl.sv
// Sequencer for the 16-bit LFSR challenge generator: seeds the LFSR, waits for each
// settled challenge, hands it to the PUF via req/ack and collects NBITS response bits.
module lfsr_challenge_ctrl #(
  parameter int NBITS   = 128,
  parameter int TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [15:0]      seed,
  output logic             lfsr_start_new,
  output logic             lfsr_next,
  output logic [15:0]      lfsr_c,
  input  logic             lfsr_en,
  input  logic [15:0]      lfsr_r,
  output logic [15:0]      puf_chal,
  output logic             puf_req,
  input  logic             puf_ack,
  input  logic             puf_resp,
  output logic [NBITS-1:0] resp,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int RW = $clog2(NBITS + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [RW-1:0] R_LAST = RW'(NBITS - 1);
  localparam logic [WW-1:0] W_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, REQ, NEXT, FIN} state_t;

  state_t           state, state_d;
  logic             sn_d, next_d, req_d, busy_d, done_d, err_d;
  logic [15:0]      c_d, chal_d;
  logic [NBITS-1:0] resp_d;
  logic [RW-1:0]    rcnt, rcnt_d;
  logic [WW-1:0]    wcnt, wcnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      lfsr_start_new <= 1'b0;
      lfsr_next      <= 1'b0;
      lfsr_c         <= '0;
      puf_chal       <= '0;
      puf_req        <= 1'b0;
      resp           <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      rcnt           <= '0;
      wcnt           <= '0;
    end else begin
      state          <= state_d;
      lfsr_start_new <= sn_d;
      lfsr_next      <= next_d;
      lfsr_c         <= c_d;
      puf_chal       <= chal_d;
      puf_req        <= req_d;
      resp           <= resp_d;
      busy           <= busy_d;
      done           <= done_d;
      err            <= err_d;
      rcnt           <= rcnt_d;
      wcnt           <= wcnt_d;
    end
  end

  // Outputs are registered, so each branch sets the value seen in the following cycle.
  always_comb begin
    state_d = state;
    sn_d    = lfsr_start_new;
    next_d  = 1'b0;
    c_d     = lfsr_c;
    chal_d  = puf_chal;
    req_d   = puf_req;
    resp_d  = resp;
    busy_d  = busy;
    done_d  = 1'b0;
    err_d   = err;
    rcnt_d  = rcnt;
    wcnt_d  = wcnt;
    case (state)
      IDLE: begin
        sn_d = 1'b0;
        if (start) begin
          c_d     = seed;
          resp_d  = '0;
          rcnt_d  = '0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        sn_d    = 1'b1;
        wcnt_d  = '0;
        state_d = RUN;
      end
      RUN: begin
        // wcnt==0 marks the first RUN cycle, where en may still be stale.
        if (wcnt != '0 && lfsr_en) begin
          chal_d  = lfsr_r;
          req_d   = 1'b1;
          state_d = REQ;
        end else if (wcnt == W_LAST) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          sn_d    = 1'b0;
          state_d = IDLE;
        end else begin
          wcnt_d = wcnt + 1'b1;
        end
      end
      REQ: begin
        if (puf_ack) begin
          req_d  = 1'b0;
          resp_d = {resp[NBITS-2:0], puf_resp};
          rcnt_d = rcnt + 1'b1;
          if (rcnt == R_LAST) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            sn_d    = 1'b0;
            state_d = FIN;
          end else begin
            next_d  = 1'b1;
            state_d = NEXT;
          end
        end
      end
      NEXT: begin
        wcnt_d  = '0;
        state_d = RUN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lfsr_challenge_ctrl.sv
// Directed bench: a 4-round instance driven from a vector table and a 128-round
// instance with random responses, each paired with a behavioural LFSR model.
module tb_lfsr_challenge_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]       start_v, sn, nx, en, req, ack_v, presp_v, busy, done, err;
  logic [1:0]       en_block;
  logic [1:0][15:0] seed_v, c, chal, r;
  logic [3:0]       resp_a;
  logic [127:0]     resp_b;

  int n_vec = 0;
  int n_bad = 0;
  int nxt_cnt[2], rq_cnt[2], dn_cnt[2];
  logic [1:0] req_q;

  lfsr_challenge_ctrl #(.NBITS(4), .TIMEOUT(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .seed(seed_v[0]),
    .lfsr_start_new(sn[0]), .lfsr_next(nx[0]), .lfsr_c(c[0]),
    .lfsr_en(en[0]), .lfsr_r(r[0]), .puf_chal(chal[0]), .puf_req(req[0]),
    .puf_ack(ack_v[0]), .puf_resp(presp_v[0]), .resp(resp_a),
    .busy(busy[0]), .done(done[0]), .err(err[0])
  );

  lfsr_challenge_ctrl #(.NBITS(128), .TIMEOUT(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .seed(seed_v[1]),
    .lfsr_start_new(sn[1]), .lfsr_next(nx[1]), .lfsr_c(c[1]),
    .lfsr_en(en[1]), .lfsr_r(r[1]), .puf_chal(chal[1]), .puf_req(req[1]),
    .puf_ack(ack_v[1]), .puf_resp(presp_v[1]), .resp(resp_b),
    .busy(busy[1]), .done(done[1]), .err(err[1])
  );

  function automatic logic [15:0] step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [15:0] lfsr_n(input logic [15:0] s, input int n);
    logic [15:0] v;
    v = s;
    for (int i = 0; i < n; i++) v = step(v);
    return v;
  endfunction

  // LFSR model: loads C while start_new=0, settles after 12 shifts, restarts on next.
  for (genvar g = 0; g < 2; g++) begin : g_lfsr
    logic [15:0] mr = '0;
    int          mc = 0;
    logic        me = 1'b0;
    always @(posedge clk) begin
      if (!sn[g]) begin
        mr <= c[g]; mc <= 0; me <= 1'b0;
      end else if (nx[g]) begin
        mc <= 0; me <= 1'b0;
      end else if (mc < 12) begin
        mr <= step(mr); mc <= mc + 1; me <= (mc == 11);
      end
    end
    assign r[g]  = mr;
    assign en[g] = me & ~en_block[g];
  end

  always @(posedge clk) begin
    req_q <= req;
    for (int i = 0; i < 2; i++) begin
      if (nx[i] === 1'b1) nxt_cnt[i] <= nxt_cnt[i] + 1;
      if (req[i] === 1'b1 && req_q[i] === 1'b0) rq_cnt[i] <= rq_cnt[i] + 1;
      if (done[i] === 1'b1) dn_cnt[i] <= dn_cnt[i] + 1;
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  function automatic logic [127:0] get_resp(input int ch);
    return (ch == 0) ? {124'b0, resp_a} : resp_b;
  endfunction

  task automatic wait_req(input int ch, output bit ok);
    int k;
    k = 0;
    while (req[ch] !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    ok = (req[ch] === 1'b1);
    if (!ok) chk("req_wait_timeout", 0, 1);
  endtask

  // One full run; lat<0 selects random latency and random response bits.
  task automatic run(input int ch, input logic [15:0] sd, input int nb,
                     input logic [127:0] bits, input int lat, input bit inject);
    logic [127:0] expv;
    int n0, r0, d0, l;
    bit b, ok;
    expv = (lat < 0) ? '0 : bits;
    n0 = nxt_cnt[ch]; r0 = rq_cnt[ch]; d0 = dn_cnt[ch];
    start_v[ch] = 1'b1; seed_v[ch] = sd;
    @(negedge clk);
    start_v[ch] = 1'b0; seed_v[ch] = 16'h0;
    chk("busy_cyc1", busy[ch], 1);
    chk("sn_cyc1", sn[ch], 0);
    chk("resp_clear", get_resp(ch), 0);
    chk("err_clear", err[ch], 0);
    @(negedge clk);
    chk("sn_cyc2", sn[ch], 1);
    if (inject) begin
      start_v[ch] = 1'b1; seed_v[ch] = 16'h1234; ack_v[ch] = 1'b1; presp_v[ch] = 1'b1;
      @(negedge clk);
      start_v[ch] = 1'b0; seed_v[ch] = 16'h0; ack_v[ch] = 1'b0; presp_v[ch] = 1'b0;
      @(negedge clk);
      chk("ignore_ack_resp", get_resp(ch), 0);
      chk("ignore_start_c", c[ch], sd);
      chk("ignore_busy", busy[ch], 1);
    end
    for (int i = 0; i < nb; i++) begin
      wait_req(ch, ok);
      if (!ok) return;
      if (i == 0) begin
        chk("first_chal", chal[ch], lfsr_n(sd, 12));
        chk("lfsr_c", c[ch], sd);
      end
      l = (lat < 0) ? int'($urandom_range(0, 5)) : lat;
      b = (lat < 0) ? 1'($urandom_range(0, 1)) : bits[nb-1-i];
      if (lat < 0) expv = {expv[126:0], b};
      repeat (l) @(negedge clk);
      ack_v[ch] = 1'b1; presp_v[ch] = b;
      @(negedge clk);
      ack_v[ch] = 1'b0; presp_v[ch] = 1'b0;
      chk("req_fall", req[ch], 0);
      if (i == nb - 1) begin
        chk("done_pulse", done[ch], 1);
        chk("busy_fall", busy[ch], 0);
      end else if (nb <= 4 || i < 2) begin
        chk("next_pulse", nx[ch], 1);
      end
    end
    chk("resp", get_resp(ch), expv);
    chk("c_const", c[ch], sd);
    @(negedge clk);
    chk("done_one_cycle", done[ch], 0);
    chk("next_count", nxt_cnt[ch] - n0, nb - 1);
    chk("req_rises", rq_cnt[ch] - r0, nb);
    chk("done_count", dn_cnt[ch] - d0, 1);
  endtask

  typedef struct {
    logic [15:0] seed;
    logic [3:0]  bits;
    int          lat;
    bit          inject;
  } vec_t;

  vec_t tbl[4];

  initial begin
    bit ok;
    int d0;
    tbl[0] = '{16'hACE1, 4'b1011, 2, 1'b0};
    tbl[1] = '{16'h0001, 4'b0110, 0, 1'b0};
    tbl[2] = '{16'hACE1, 4'b1011, 1, 1'b1};
    tbl[3] = '{16'h5A5A, 4'b0001, 5, 1'b0};

    rst_n = 1'b0;
    start_v = '0; seed_v = '0; ack_v = '0; presp_v = '0; en_block = '0;
    repeat (2) @(negedge clk);
    for (int ch = 0; ch < 2; ch++) begin
      chk("reset_outs", {sn[ch], nx[ch], c[ch], chal[ch], req[ch], busy[ch], done[ch], err[ch]}, 0);
      chk("reset_resp", get_resp(ch), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Table runs are back-to-back: each starts the cycle after the previous done.
    for (int i = 0; i < 4; i++)
      run(0, tbl[i].seed, 4, {124'b0, tbl[i].bits}, tbl[i].lat, tbl[i].inject);

    // Reset while in REQ of round 2 with a partial response already collected.
    start_v[0] = 1'b1; seed_v[0] = 16'hACE1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_req(0, ok);
    ack_v[0] = 1'b1; presp_v[0] = 1'b1;
    @(negedge clk);
    ack_v[0] = 1'b0; presp_v[0] = 1'b0;
    wait_req(0, ok);
    chk("partial_resp", resp_a, 4'b0001);
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_outs", {sn[0], nx[0], c[0], chal[0], req[0], busy[0], done[0], err[0]}, 0);
    chk("midrun_reset_resp", resp_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(0, 16'hACE1, 4, {124'b0, 4'b1011}, 2, 1'b0);

    // Timeout: en never rises, so 32 RUN cycles (cycles 2..33) elapse.
    en_block[0] = 1'b1;
    d0 = dn_cnt[0];
    start_v[0] = 1'b1; seed_v[0] = 16'hACE1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (32) @(negedge clk);
    chk("timeout_err_early", err[0], 0);
    chk("timeout_busy_early", busy[0], 1);
    @(negedge clk);
    chk("timeout_err", err[0], 1);
    chk("timeout_busy", busy[0], 0);
    chk("timeout_sn", sn[0], 0);
    chk("timeout_no_done", dn_cnt[0] - d0, 0);
    en_block[0] = 1'b0;
    run(0, 16'h0001, 4, {124'b0, 4'b0110}, 0, 1'b0);

    run(1, 16'hC0DE, 128, '0, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
